// File: rtl/ram_init_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : ram_init_pkg                                                    |
// | Brief  : Shared FSM encoding, default geometry and width helpers for the |
// |          cache line RAM read arbiter.                                    |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package ram_init_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int N_REQ_DEF       = 2;
  localparam int CACHE_LINE_DEF  = 128;
  localparam int CACHE_DEPTH_DEF = 32;
  localparam int DATA_WIDTH_DEF  = 32;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int offs_width(input int line_w, input int data_w);
    return $clog2(line_w / data_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_init_rd_arb_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : rr_arbiter                                                      |
// | Brief  : Round-robin arbiter, one-hot grant from a rotating pointer.     |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             accept_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0] idx_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_cand;
  logic             w_found;

  // Scan cyclically starting at the pointer; first requester found wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(N_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(N_REQ);
      end
      w_cand = w_sum[PTR_W-1:0];
      if (!w_found && req_i[w_cand]) begin
        w_found       = 1'b1;
        gnt_o[w_cand] = 1'b1;
        idx_o         = w_cand;
      end
    end
  end

  always_comb begin
    ptr_d = (idx_o == PTR_W'(N_REQ-1)) ? '0 : idx_o + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (accept_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_init_rd_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : ram_init_rd_arb                                                 |
// | Brief  : Round-robin read arbiter in front of the cache line RAM;        |
// |          returns the addressed word to the winning requester.            |
// |          Optional one-line buffer: RAM_INIT_RD_ARB_LINE_BUF_EN           |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module ram_init_rd_arb
  import ram_init_pkg::*;
#(
  parameter  int N_REQ       = N_REQ_DEF,
  parameter  int CACHE_LINE  = CACHE_LINE_DEF,
  parameter  int CACHE_DEPTH = CACHE_DEPTH_DEF,
  parameter  int DATA_WIDTH  = DATA_WIDTH_DEF,
  localparam int ADDR_WIDTH  = addr_width(CACHE_DEPTH),
  localparam int N_DATA_LINE = CACHE_LINE / DATA_WIDTH,
  localparam int OFFS_WIDTH  = offs_width(CACHE_LINE, DATA_WIDTH),
  localparam int WADDR_WIDTH = ADDR_WIDTH + OFFS_WIDTH,
  localparam int ID_WIDTH    = $clog2(N_REQ)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_REQ-1:0]             req_valid_i,
  input  logic [N_REQ*WADDR_WIDTH-1:0] req_waddr_i,
  output logic [N_REQ-1:0]             req_ready_o,
  output logic [N_REQ-1:0]             rsp_valid_o,
  output logic [DATA_WIDTH-1:0]        rsp_data_o,
  input  logic [N_REQ-1:0]             rsp_ready_i,
  output logic [ADDR_WIDTH-1:0]        ram_addr_o,
  input  logic [CACHE_LINE-1:0]        ram_data_i,
  output logic                         busy_o
);

  state_e                                   state_q;
  logic [ADDR_WIDTH-1:0]                    addr_q;
  logic [OFFS_WIDTH-1:0]                    offs_q;
  logic [N_REQ-1:0]                         id_q;
  logic [DATA_WIDTH-1:0]                    data_q;
  logic [N_REQ-1:0]                         rsp_vld_q;

  logic [N_REQ-1:0]                         w_gnt;
  logic [ID_WIDTH-1:0]                      w_idx;
  logic                                     w_accept;
  logic [N_REQ-1:0][WADDR_WIDTH-1:0]        w_waddrs;
  logic [WADDR_WIDTH-1:0]                   w_waddr;
  logic [ADDR_WIDTH-1:0]                    w_line;
  logic [OFFS_WIDTH-1:0]                    w_offs;
  logic [N_DATA_LINE-1:0][DATA_WIDTH-1:0]   w_ram_words;
  logic                                     w_hit;
  logic [DATA_WIDTH-1:0]                    w_buf_word;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_valid_i),
    .accept_i (w_accept),
    .gnt_o    (w_gnt),
    .idx_o    (w_idx)
  );

  assign w_accept    = (state_q == ST_IDLE) && (|req_valid_i);
  assign w_waddrs    = req_waddr_i;
  assign w_waddr     = w_waddrs[w_idx];
  assign w_line      = w_waddr[WADDR_WIDTH-1:OFFS_WIDTH];
  assign w_offs      = w_waddr[OFFS_WIDTH-1:0];
  assign w_ram_words = ram_data_i;

`ifdef RAM_INIT_RD_ARB_LINE_BUF_EN
  logic                                   buf_vld_q;
  logic [ADDR_WIDTH-1:0]                  buf_line_q;
  logic [N_DATA_LINE-1:0][DATA_WIDTH-1:0] buf_data_q;

  // RAM is read-only, so the captured line stays valid until reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_vld_q  <= 1'b0;
      buf_line_q <= '0;
      buf_data_q <= '0;
    end else if (state_q == ST_DATA) begin
      buf_vld_q  <= 1'b1;
      buf_line_q <= addr_q;
      buf_data_q <= ram_data_i;
    end
  end

  assign w_hit      = buf_vld_q && (buf_line_q == w_line);
  assign w_buf_word = buf_data_q[w_offs];
`else
  assign w_hit      = 1'b0;
  assign w_buf_word = '0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      offs_q    <= '0;
      id_q      <= '0;
      data_q    <= '0;
      rsp_vld_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            offs_q <= w_offs;
            id_q   <= w_gnt;
            if (w_hit) begin
              data_q    <= w_buf_word;
              rsp_vld_q <= w_gnt;
              state_q   <= ST_RESP;
            end else begin
              addr_q  <= w_line;
              state_q <= ST_ADDR;
            end
          end
        end
        ST_ADDR: state_q <= ST_DATA;
        ST_DATA: begin
          data_q    <= w_ram_words[offs_q];
          rsp_vld_q <= id_q;
          state_q   <= ST_RESP;
        end
        ST_RESP: begin
          if (|(rsp_vld_q & rsp_ready_i)) begin
            rsp_vld_q <= '0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = ((state_q == ST_IDLE) && !rst_i) ? w_gnt : '0;
  assign rsp_valid_o = rsp_vld_q;
  assign rsp_data_o  = data_q;
  assign ram_addr_o  = addr_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
